// File: rtl/grf_wb_queue.sv
// grf_wb_queue: write-side companion to the general register file.
//
// Merges register writes from the pipeline writeback stage (source A) and the
// multi-cycle mul/div unit (source B) into the GRF's single write port. Writes
// are buffered in an in-order circular FIFO and drained one per cycle. A lookup
// port lets decode forward values that are pending but not yet committed.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 2)
//
// Ports:
//   Clk, Reset                   clock (rising edge), async active-low reset
//   A_Valid/A_Addr/A_Data/A_PC   writeback request; A_Stall = not accepted
//   B_Valid/B_Addr/B_Data/B_PC   mul/div request (held until B_Ready)
//   B_Ready                      B accepted this cycle
//   W_En/W_Addr/W_Data/W_PC      GRF write port, driven from the head entry
//   Q_Addr -> Q_Hit/Q_Data       youngest pending write to Q_Addr
//   Count                        current occupancy
//
// Optional feature macro: WBQ_TRACE_EN enables a simulation-only commit trace
// ("@pc: $reg <= data") printed on every committing edge.
module grf_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     A_Valid,
  input  logic [4:0]               A_Addr,
  input  logic [31:0]              A_Data,
  input  logic [31:0]              A_PC,
  output logic                     A_Stall,
  input  logic                     B_Valid,
  output logic                     B_Ready,
  input  logic [4:0]               B_Addr,
  input  logic [31:0]              B_Data,
  input  logic [31:0]              B_PC,
  output logic                     W_En,
  output logic [4:0]               W_Addr,
  output logic [31:0]              W_Data,
  output logic [31:0]              W_PC,
  input  logic [4:0]               Q_Addr,
  output logic                     Q_Hit,
  output logic [31:0]              Q_Data,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] a_slot;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          need_a;
  logic          need_b;
  logic          enq_a;
  logic          enq_b;
  logic          deq;

  // Acceptance is judged on pre-edge occupancy; the dequeue happening on the
  // same edge is deliberately not credited. A claims space before B.
  always_comb begin
    free    = CW'(DEPTH) - count;
    need_a  = A_Valid && (A_Addr != 5'd0);
    need_b  = B_Valid && (B_Addr != 5'd0);
    A_Stall = need_a && (free == '0);
    enq_a   = need_a && !A_Stall;
    B_Ready = B_Valid && (!need_b || (free >= (need_a ? CW'(2) : CW'(1))));
    enq_b   = need_b && B_Ready;
    deq     = (count != '0);
    // B is the older instruction, so it takes the first free slot.
    a_slot  = wr_ptr + PW'(enq_b);
  end

  // Entry storage: data only, never reset.
  always_ff @(posedge Clk) begin
    if (enq_b) begin
      addr_mem[wr_ptr] <= B_Addr;
      data_mem[wr_ptr] <= B_Data;
      pc_mem[wr_ptr]   <= B_PC;
    end
    if (enq_a) begin
      addr_mem[a_slot] <= A_Addr;
      data_mem[a_slot] <= A_Data;
      pc_mem[a_slot]   <= A_PC;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(deq);
      wr_ptr <= wr_ptr + PW'(enq_a) + PW'(enq_b);
      count  <= count + CW'(enq_a) + CW'(enq_b) - CW'(deq);
    end
  end

  // Outputs are gated by occupancy so that an asynchronous reset zeroes them
  // immediately even though the storage keeps its old contents.
  always_comb begin
    W_En   = deq;
    W_Addr = deq ? addr_mem[rd_ptr] : 5'd0;
    W_Data = deq ? data_mem[rd_ptr] : 32'd0;
    W_PC   = deq ? pc_mem[rd_ptr]   : 32'd0;
    Count  = count;
  end

  // Scan oldest to youngest so the last match (closest to the tail) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = rd_ptr;
    Q_Hit  = 1'b0;
    Q_Data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (Q_Addr != 5'd0) && (addr_mem[idx] == Q_Addr)) begin
        Q_Hit  = 1'b1;
        Q_Data = data_mem[idx];
      end
    end
  end

`ifdef WBQ_TRACE_EN
  always @(posedge Clk) begin
    if (Reset && W_En) begin
      $display("@%h: $%d <= %h", W_PC, W_Addr, W_Data);
    end
  end
`else
`endif

endmodule

// File: tb/tb_grf_wb_queue.sv
module tb_grf_wb_queue;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Reset;
  logic        A_Valid;
  logic [4:0]  A_Addr;
  logic [31:0] A_Data;
  logic [31:0] A_PC;
  logic        A_Stall;
  logic        B_Valid;
  logic        B_Ready;
  logic [4:0]  B_Addr;
  logic [31:0] B_Data;
  logic [31:0] B_PC;
  logic        W_En;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic [31:0] W_PC;
  logic [4:0]  Q_Addr;
  logic        Q_Hit;
  logic [31:0] Q_Data;
  logic [2:0]  Count;

  int errors = 0;
  int checks = 0;

  grf_wb_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data), .A_PC(A_PC), .A_Stall(A_Stall),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Addr(B_Addr), .B_Data(B_Data), .B_PC(B_PC),
    .W_En(W_En), .W_Addr(W_Addr), .W_Data(W_Data), .W_PC(W_PC),
    .Q_Addr(Q_Addr), .Q_Hit(Q_Hit), .Q_Data(Q_Data), .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the pending writes as a plain in-order list.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t mq[$];

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mq.delete();
    end else begin
      int  fr;
      bit  na, nb, ea, eb;
      ent_t ent;
      fr = DEPTH - mq.size();
      na = A_Valid && (A_Addr != 0);
      nb = B_Valid && (B_Addr != 0);
      ea = na && (fr >= 1);
      eb = nb && (fr >= (na ? 2 : 1));
      if (mq.size() != 0) void'(mq.pop_front());
      if (eb) begin
        ent.a = B_Addr; ent.d = B_Data; ent.p = B_PC;
        mq.push_back(ent);
      end
      if (ea) begin
        ent.a = A_Addr; ent.d = A_Data; ent.p = A_PC;
        mq.push_back(ent);
      end
    end
  end

  // Compare every output against the model at each falling edge.
  always @(negedge Clk) begin
    int          sz, fr;
    bit          na, nb, e_hit;
    logic [31:0] e_qd;
    sz = mq.size();
    fr = DEPTH - sz;
    na = A_Valid && (A_Addr != 0);
    nb = B_Valid && (B_Addr != 0);
    e_hit = 1'b0;
    e_qd  = 32'd0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (Q_Addr != 0 && mq[i].a == Q_Addr) begin
        e_hit = 1'b1;
        e_qd  = mq[i].d;
        break;
      end
    end
    chk("m_count",  32'(Count), 32'(sz));
    chk("m_w_en",   32'(W_En), 32'(sz != 0));
    chk("m_w_addr", 32'(W_Addr), (sz != 0) ? 32'(mq[0].a) : 32'd0);
    chk("m_w_data", W_Data, (sz != 0) ? mq[0].d : 32'd0);
    chk("m_w_pc",   W_PC, (sz != 0) ? mq[0].p : 32'd0);
    chk("m_a_stall", 32'(A_Stall), 32'(na && fr == 0));
    chk("m_b_ready", 32'(B_Ready), 32'(B_Valid && (!nb || fr >= (na ? 2 : 1))));
    chk("m_q_hit",  32'(Q_Hit), 32'(e_hit));
    chk("m_q_data", Q_Data, e_qd);
  end

  task automatic idle_inputs();
    A_Valid = 0; A_Addr = 0; A_Data = 0; A_PC = 0;
    B_Valid = 0; B_Addr = 0; B_Data = 0; B_PC = 0;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    bit a_ok, b_ok;
    Reset = 1'b0;
    Q_Addr = 0;
    idle_inputs();
    next_cycle();
    next_cycle();
    chk("rst_w_en", 32'(W_En), 0);
    chk("rst_count", 32'(Count), 0);
    chk("rst_a_stall", 32'(A_Stall), 0);
    chk("rst_b_ready", 32'(B_Ready), 0);
    @(negedge Clk);
    Reset = 1'b1;
    next_cycle();

    // Single A write: visible the cycle after acceptance, gone one cycle later.
    A_Valid = 1; A_Addr = 5; A_Data = 32'h1234; A_PC = 32'h3000;
    next_cycle();
    idle_inputs();
    chk("t1_w_en", 32'(W_En), 1);
    chk("t1_w_addr", 32'(W_Addr), 5);
    chk("t1_w_data", W_Data, 32'h1234);
    chk("t1_w_pc", W_PC, 32'h3000);
    chk("t1_count", 32'(Count), 1);
    next_cycle();
    chk("t1_w_en_off", 32'(W_En), 0);
    chk("t1_count_off", 32'(Count), 0);

    // A and B together: B commits first.
    A_Valid = 1; A_Addr = 3; A_Data = 32'hA; A_PC = 32'h100;
    B_Valid = 1; B_Addr = 4; B_Data = 32'hB; B_PC = 32'h0FC;
    #3;
    chk("t2_b_ready", 32'(B_Ready), 1);
    chk("t2_a_stall", 32'(A_Stall), 0);
    next_cycle();
    idle_inputs();
    chk("t2_first_addr", 32'(W_Addr), 4);
    chk("t2_first_data", W_Data, 32'hB);
    chk("t2_count", 32'(Count), 2);
    next_cycle();
    chk("t2_second_addr", 32'(W_Addr), 3);
    chk("t2_second_data", W_Data, 32'hA);
    next_cycle();
    chk("t2_empty", 32'(Count), 0);

    // Writes to $0 are accepted and discarded.
    A_Valid = 1; A_Addr = 0; A_Data = 32'hDEAD;
    B_Valid = 1; B_Addr = 0; B_Data = 32'hBEEF;
    #3;
    chk("t3_a_stall", 32'(A_Stall), 0);
    chk("t3_b_ready", 32'(B_Ready), 1);
    next_cycle();
    idle_inputs();
    chk("t3_count", 32'(Count), 0);
    chk("t3_w_en", 32'(W_En), 0);

    // Forwarding: youngest of two pending writes to reg 9 wins.
    B_Valid = 1; B_Addr = 9; B_Data = 32'h11; B_PC = 32'h200;
    A_Valid = 1; A_Addr = 9; A_Data = 32'h22; A_PC = 32'h204;
    next_cycle();
    idle_inputs();
    Q_Addr = 9;
    #1;
    chk("t4_hit", 32'(Q_Hit), 1);
    chk("t4_data", Q_Data, 32'h22);
    Q_Addr = 0;
    #1;
    chk("t4_zero_hit", 32'(Q_Hit), 0);
    chk("t4_zero_data", Q_Data, 0);
    Q_Addr = 4;
    #1;
    chk("t4_stale_hit", 32'(Q_Hit), 0);
    next_cycle();
    next_cycle();
    next_cycle();

    // Near-full: at Count=3 only A fits, B must wait.
    A_Valid = 1; A_Addr = 10; A_Data = 32'h10A; A_PC = 32'h300;
    B_Valid = 1; B_Addr = 11; B_Data = 32'h10B; B_PC = 32'h2FC;
    next_cycle();
    chk("t5_count2", 32'(Count), 2);
    next_cycle();
    chk("t5_count3", 32'(Count), 3);
    #3;
    chk("t5_a_stall", 32'(A_Stall), 0);
    chk("t5_b_ready", 32'(B_Ready), 0);
    next_cycle();
    chk("t5_count_hold", 32'(Count), 3);
    A_Valid = 0;
    #3;
    chk("t5_b_ready_idle", 32'(B_Ready), 1);
    next_cycle();
    idle_inputs();
    chk("t5_count_after", 32'(Count), 3);
    Q_Addr = 11;
    #1;
    chk("t6_hit_pre", 32'(Q_Hit), 1);

    // Asynchronous reset mid-drain.
    Reset = 1'b0;
    #1;
    chk("t6_w_en", 32'(W_En), 0);
    chk("t6_count", 32'(Count), 0);
    chk("t6_w_addr", 32'(W_Addr), 0);
    chk("t6_hit", 32'(Q_Hit), 0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      chk("t6_no_stale", 32'(W_En), 0);
    end

    // Randomised traffic; held requests stay stable until accepted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge Clk);
      a_ok = !(A_Valid && A_Stall);
      b_ok = !(B_Valid && !B_Ready);
      next_cycle();
      if (a_ok) begin
        A_Valid = ($urandom_range(0, 3) != 0);
        A_Addr  = 5'($urandom_range(0, 7));
        A_Data  = $urandom;
        A_PC    = $urandom;
      end
      if (b_ok) begin
        B_Valid = ($urandom_range(0, 2) == 0);
        B_Addr  = 5'($urandom_range(0, 7));
        B_Data  = $urandom;
        B_PC    = $urandom;
      end
      Q_Addr = 5'($urandom_range(0, 7));
      if (n % 700 == 350) begin
        #1 Reset = 1'b0;
        #2 Reset = 1'b1;
      end
    end

    @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
